mips_bus_arbiter: RTL and testbench

Shares the single Avalon memory-mapped master of the MIPS I CPU between two internal requesters: the instruction-fetch port and the load/store data port. It accepts one request at a time, latches it, drives the Avalon handshake until `waitrequest` drops, and returns read data with a one-cycle `done` pulse. It sits between the CPU control FSM (FETCH/EXEC states) and the external bus pins `address`/`read`/`write`/`writedata`/`byteenable`/`readdata`/`waitrequest`.

---
 rtl/mips_bus_pkg.sv | 17 +
 rtl/mips_bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_mips_bus_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS bus arbiter.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUS,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    GNT_FETCH,
    GNT_DATA
  } grant_t;

  localparam logic [3:0] BYTEEN_WORD = 4'b1111;

endpackage

// File: rtl/mips_bus_arbiter.sv
// Two-requester arbiter in front of the CPU's single Avalon-MM master.
// Fetch and load/store ports share one bus. A request is sampled only in
// IDLE. It is latched and driven onto the bus until waitrequest drops, then
// answered with a one-cycle done pulse in RESP.
//
// Requester handshake: req is a level, sampled only in IDLE and held until the
// matching done pulse. The requester drops req during the done (RESP) cycle;
// a req still high in IDLE after that starts a new transaction.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter bit FAIR = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_done,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        busy,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  arb_state_t  r_state;
  arb_state_t  w_next_state;
  grant_t      r_last_grant;
  grant_t      w_grant;
  logic        w_grant_valid;
  logic        w_bus_done;

  logic [31:0] r_addr;
  logic        r_write;
  logic [31:0] r_wdata;
  logic [3:0]  r_byteenable;
  logic [31:0] r_f_rdata;
  logic [31:0] r_d_rdata;
  logic        r_f_done;
  logic        r_d_done;

  // Transfer completes on the edge where BUS sees waitrequest low.
  assign w_bus_done = (r_state == ARB_BUS) && !waitrequest;

  // Grant selection and next-state logic.
  always_comb begin
    w_next_state  = r_state;
    w_grant       = GNT_DATA;
    w_grant_valid = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (f_req || d_req) begin
          w_grant_valid = 1'b1;
          w_next_state  = ARB_BUS;
          if (f_req && !d_req) begin
            w_grant = GNT_FETCH;
          end else if (!f_req && d_req) begin
            w_grant = GNT_DATA;
          end else if (FAIR) begin
            // Contested: hand the bus to whoever did not have it last.
            w_grant = (r_last_grant == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
          end else begin
            w_grant = GNT_DATA;
          end
        end
      end
      ARB_BUS: begin
        if (!waitrequest) begin
          w_next_state = ARB_RESP;
        end
      end
      ARB_RESP: begin
        w_next_state = ARB_IDLE;
      end
      default: begin
        w_next_state = ARB_IDLE;
      end
    endcase
  end

  // State register; reset abandons any in-flight transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch the granted request; these hold outside BUS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr       <= 32'h0;
      r_write      <= 1'b0;
      r_wdata      <= 32'h0;
      r_byteenable <= 4'h0;
      r_last_grant <= GNT_DATA;
    end else if ((r_state == ARB_IDLE) && w_grant_valid) begin
      r_last_grant <= w_grant;
      if (w_grant == GNT_FETCH) begin
        r_addr       <= f_addr;
        r_write      <= 1'b0;
        r_wdata      <= 32'h0;
        r_byteenable <= BYTEEN_WORD;
      end else begin
        r_addr       <= d_addr;
        r_write      <= d_write;
        r_wdata      <= d_wdata;
        r_byteenable <= d_byteenable;
      end
    end
  end

  // Completion: capture read data and raise the owner's done for RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_f_rdata <= 32'h0;
      r_d_rdata <= 32'h0;
      r_f_done  <= 1'b0;
      r_d_done  <= 1'b0;
    end else begin
      r_f_done <= w_bus_done && (r_last_grant == GNT_FETCH);
      r_d_done <= w_bus_done && (r_last_grant == GNT_DATA);
      if (w_bus_done && !r_write) begin
        if (r_last_grant == GNT_FETCH) begin
          r_f_rdata <= readdata;
        end else begin
          r_d_rdata <= readdata;
        end
      end
    end
  end

  // Bus strobes exist only in BUS; the word address drops the byte offset.
  assign read       = (r_state == ARB_BUS) && !r_write;
  assign write      = (r_state == ARB_BUS) && r_write;
  assign address    = r_addr & 32'hFFFF_FFFC;
  assign writedata  = r_wdata;
  assign byteenable = r_byteenable;
  assign busy       = (r_state != ARB_IDLE);
  assign f_done     = r_f_done;
  assign d_done     = r_d_done;
  assign f_rdata    = r_f_rdata;
  assign d_rdata    = r_d_rdata;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: one FAIR=0 and one FAIR=1 instance on
// shared request inputs, each with its own memory model on the bus side.
module tb_mips_bus_arbiter;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        f_req, d_req, d_write, waitrequest;
  logic [31:0] f_addr, d_addr, d_wdata;
  logic [3:0]  d_be;

  // ---------------- per-instance outputs ----------------
  logic        f_done0, d_done0, busy0, read0, write0;
  logic [31:0] f_rdata0, d_rdata0, address0, writedata0, readdata0;
  logic [3:0]  byteenable0;
  logic        f_done1, d_done1, busy1, read1, write1;
  logic [31:0] f_rdata1, d_rdata1, address1, writedata1, readdata1;
  logic [3:0]  byteenable1;

  // Memory model: one fixed boot word, everything else address-derived.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'hBFC0_0000) ? 32'h2402_0005 : (a ^ 32'hA5A5_5A5A);
  endfunction

  assign readdata0 = mem(address0);
  assign readdata1 = mem(address1);

  mips_bus_arbiter #(.FAIR(1'b0)) u0 (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done0), .f_rdata(f_rdata0),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_be), .d_done(d_done0), .d_rdata(d_rdata0),
    .busy(busy0), .address(address0), .read(read0), .write(write0),
    .writedata(writedata0), .byteenable(byteenable0),
    .waitrequest(waitrequest), .readdata(readdata0)
  );

  mips_bus_arbiter #(.FAIR(1'b1)) u1 (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done1), .f_rdata(f_rdata1),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_be), .d_done(d_done1), .d_rdata(d_rdata1),
    .busy(busy1), .address(address1), .read(read1), .write(write1),
    .writedata(writedata1), .byteenable(byteenable1),
    .waitrequest(waitrequest), .readdata(readdata1)
  );

  // ---------------- scoreboard ----------------
  // Entry: {is_data, rdata expected on the done pulse}.
  logic [32:0] exp0_q[$];
  logic [32:0] exp1_q[$];
  logic        mon0_en, mon1_en;
  int          n_checks;
  int          n_fail;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int k, input logic fd, input logic dd,
                     input logic [31:0] fr, input logic [31:0] dr);
    logic [32:0] e;
    int          sz;
    if (fd || dd) begin
      check((k == 0) ? "done_excl0" : "done_excl1", {32'h0, fd && dd}, 33'h0);
      sz = (k == 0) ? exp0_q.size() : exp1_q.size();
      n_checks++;
      assert (sz > 0) else begin
        n_fail++;
        $error("FAIL unexpected_done%0d: observed done with %0d queued expected 1+", k, sz);
      end
      if (sz > 0) begin
        e = (k == 0) ? exp0_q.pop_front() : exp1_q.pop_front();
        check((k == 0) ? "done_kind0" : "done_kind1", {32'h0, dd}, {32'h0, e[32]});
        check((k == 0) ? "rdata0" : "rdata1", {1'b0, dd ? dr : fr}, {1'b0, e[31:0]});
      end
    end
  endtask

  // Advance one cycle and sample on the falling edge.
  task automatic tick();
    @(negedge clk);
    check("rw_excl0", {32'h0, read0 & write0}, 33'h0);
    check("rw_excl1", {32'h0, read1 & write1}, 33'h0);
    if (mon0_en) mon(0, f_done0, d_done0, f_rdata0, d_rdata0);
    if (mon1_en) mon(1, f_done1, d_done1, f_rdata1, d_rdata1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] exp_addr;
    n_checks = 0; n_fail = 0;
    mon0_en = 1'b1; mon1_en = 1'b1;
    reset = 1'b1;
    f_req = 0; d_req = 0; d_write = 0; waitrequest = 0;
    f_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0;

    // Reset state
    @(negedge clk);
    check("rst_busy", {32'h0, busy0}, 33'h0);
    check("rst_read", {32'h0, read0 | write0}, 33'h0);
    check("rst_done", {32'h0, f_done0 | d_done0}, 33'h0);
    check("rst_addr", {1'b0, address0}, 33'h0);
    check("rst_frdata", {1'b0, f_rdata0}, 33'h0);
    reset = 1'b0;

    // Single fetch with unaligned address
    f_addr = 32'hBFC0_0002; f_req = 1;
    exp0_q.push_back({1'b0, 32'h2402_0005});
    exp1_q.push_back({1'b0, 32'h2402_0005});
    tick();
    check("f_addr", {1'b0, address0}, {1'b0, 32'hBFC0_0000});
    check("f_read", {32'h0, read0}, 33'h1);
    check("f_busy", {32'h0, busy0}, 33'h1);
    check("f_be", {29'h0, byteenable0}, {29'h0, 4'hF});
    tick();
    check("f_resp_read", {32'h0, read0}, 33'h0);
    check("f_resp_busy", {32'h0, busy0}, 33'h1);
    f_req = 0;
    tick();
    check("f_idle_busy", {32'h0, busy0}, 33'h0);

    // Load, then a store that must leave d_rdata alone
    d_addr = 32'h0000_2008; d_write = 0; d_be = 4'hF; d_req = 1;
    exp0_q.push_back({1'b1, mem(32'h0000_2008)});
    exp1_q.push_back({1'b1, mem(32'h0000_2008)});
    tick();
    check("ld_read", {32'h0, read0}, 33'h1);
    tick();
    d_req = 0;
    tick();

    d_addr = 32'h0000_1004; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    d_write = 1; d_req = 1; waitrequest = 1;
    exp0_q.push_back({1'b1, mem(32'h0000_2008)});
    exp1_q.push_back({1'b1, mem(32'h0000_2008)});
    for (int i = 0; i < 4; i++) begin
      tick();
      check("st_write", {32'h0, write0}, 33'h1);
      check("st_read", {32'h0, read0}, 33'h0);
      check("st_addr", {1'b0, address0}, {1'b0, 32'h0000_1004});
      check("st_wdata", {1'b0, writedata0}, {1'b0, 32'hDEAD_BEEF});
      check("st_be", {29'h0, byteenable0}, {29'h0, 4'b0011});
      waitrequest = (i == 3) ? 1'b0 : 1'b1;
    end
    tick();
    check("st_resp_write", {32'h0, write0}, 33'h0);
    check("st_resp_ddone", {32'h0, d_done0}, 33'h1);
    d_req = 0; d_write = 0;
    tick();
    check("st_single_pulse", {32'h0, d_done0}, 33'h0);

    // Contested, FAIR=0: data first, fetch strobe two cycles after d_done
    pulse_reset();
    mon1_en = 1'b0;
    f_addr = 32'h0000_0100; d_addr = 32'h0000_2008; d_be = 4'hF;
    f_req = 1; d_req = 1;
    exp0_q.push_back({1'b1, mem(32'h0000_2008)});
    exp0_q.push_back({1'b0, mem(32'h0000_0100)});
    tick();
    check("p0_first_addr", {1'b0, address0}, {1'b0, 32'h0000_2008});
    tick();
    check("p0_ddone", {32'h0, d_done0}, 33'h1);
    d_req = 0;
    tick();
    check("p0_gap_read", {32'h0, read0}, 33'h0);
    tick();
    check("p0_f_read", {32'h0, read0}, 33'h1);
    check("p0_f_addr", {1'b0, address0}, {1'b0, 32'h0000_0100});
    tick();
    f_req = 0;
    tick();

    // Contested, FAIR=1: F, D, F, D with both held throughout
    pulse_reset();
    mon0_en = 1'b0; mon1_en = 1'b1;
    f_req = 1; d_req = 1;
    for (int i = 0; i < 4; i++) begin
      exp1_q.push_back((i % 2 == 0) ? {1'b0, mem(32'h0000_0100)} : {1'b1, mem(32'h0000_2008)});
    end
    for (int i = 0; i < 4; i++) begin
      exp_addr = (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_2008;
      tick();
      check("fair_addr", {1'b0, address1}, {1'b0, exp_addr});
      check("fair_read", {32'h0, read1}, 33'h1);
      tick();
      check("fair_resp_read", {32'h0, read1}, 33'h0);
      tick();
      check("fair_idle_busy", {32'h0, busy1}, 33'h0);
    end
    f_req = 0; d_req = 0;
    tick();

    // Req held through RESP: no duplicate, then a clean re-grant
    pulse_reset();
    mon0_en = 1'b1;
    f_addr = 32'h0000_0040; f_req = 1;
    exp0_q.push_back({1'b0, mem(32'h0000_0040)});
    exp1_q.push_back({1'b0, mem(32'h0000_0040)});
    tick();
    tick();
    check("hold_resp_read", {32'h0, read0}, 33'h0);
    tick();
    check("hold_idle_busy", {32'h0, busy0}, 33'h0);
    f_req = 0;
    tick();
    check("hold_no_dup", {32'h0, busy0 | read0}, 33'h0);
    f_addr = 32'h0000_0080; f_req = 1;
    exp0_q.push_back({1'b0, mem(32'h0000_0080)});
    exp1_q.push_back({1'b0, mem(32'h0000_0080)});
    tick();
    check("regrant_addr", {1'b0, address0}, {1'b0, 32'h0000_0080});
    tick();
    f_req = 0;
    tick();

    // Reset mid-BUS under waitrequest
    f_addr = 32'h0000_0300; f_req = 1; waitrequest = 1;
    tick();
    check("mid_read", {32'h0, read0}, 33'h1);
    tick();
    check("mid_read_held", {32'h0, read0}, 33'h1);
    reset = 1'b1;
    #1;
    check("mid_rst_read", {32'h0, read0 | read1}, 33'h0);
    check("mid_rst_write", {32'h0, write0 | write1}, 33'h0);
    check("mid_rst_busy", {32'h0, busy0 | busy1}, 33'h0);
    check("mid_rst_done", {32'h0, f_done0 | d_done0 | f_done1 | d_done1}, 33'h0);
    check("mid_rst_addr", {1'b0, address0}, 33'h0);
    #1;
    reset = 1'b0;
    f_req = 0; waitrequest = 0;
    tick();
    check("post_rst_idle", {32'h0, busy0}, 33'h0);
    f_addr = 32'h0000_0300; f_req = 1;
    exp0_q.push_back({1'b0, mem(32'h0000_0300)});
    exp1_q.push_back({1'b0, mem(32'h0000_0300)});
    tick();
    check("reissue_read", {32'h0, read0}, 33'h1);
    tick();
    check("reissue_fdone", {32'h0, f_done0}, 33'h1);
    f_req = 0;
    tick();

    check("q0_empty", {1'b0, 32'(exp0_q.size())}, 33'h0);
    check("q1_empty", {1'b0, 32'(exp1_q.size())}, 33'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
